// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam int unsigned DEPTH_DEF     = 64;
    localparam int unsigned BURST_MAX_DEF = 4;

    function automatic port_id_t other_port(port_id_t p);
        return ~p;
    endfunction

    function automatic arb_state_t own_state(port_id_t p);
        return p ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          err;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
        output ack0, ack1, rdata0, rdata1, err, mem_a, mem_wd, mem_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
        input  ack0, ack1, rdata0, rdata1, err, mem_a, mem_wd, mem_we
    );

endinterface

// File: rtl/dmem_arb_rr_pick.sv
// Combinational round-robin pick between two requesters; rr_ptr breaks ties.
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t rr_ptr,
    output port_id_t winner,
    output logic     any_req
);

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = rr_ptr;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded bursts in front of a 64x32 data memory.
// Optional range check enabled by defining DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CntW = $clog2(BURST_MAX + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntMax = cnt_t'(BURST_MAX);

    arb_state_t    state_q, state_d;
    port_id_t      rr_ptr_q, rr_ptr_d;
    cnt_t          beat_cnt_q, beat_cnt_d;
    cnt_t          cnt_inc;

    port_id_t      winner;
    logic          any_req;
    port_id_t      own;
    port_id_t      oth;
    logic          req_own;
    logic          req_oth;
    logic          we_own;
    logic [AW-1:0] addr_own;
    logic [DW-1:0] wdata_own;
    logic          beat;
    logic          oor;

    dmem_arb_rr_pick u_rr_pick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Select the current owner's fields; the non-owner never reaches the memory.
    always_comb begin
        own       = (state_q == OWN1);
        oth       = other_port(own);
        req_own   = own ? bus.req1   : bus.req0;
        req_oth   = own ? bus.req0   : bus.req1;
        we_own    = own ? bus.we1    : bus.we0;
        addr_own  = own ? bus.addr1  : bus.addr0;
        wdata_own = own ? bus.wdata1 : bus.wdata0;
        beat      = (state_q != IDLE) && req_own;
    end

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign oor     = addr_own >= AW'(DEPTH);
    assign bus.err = beat && oor;
`else
    assign oor     = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        cnt_inc    = (beat_cnt_q == CntMax) ? CntMax : beat_cnt_q + cnt_t'(1);

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = own_state(winner);
                    beat_cnt_d = '0;
                end
            end
            OWN0, OWN1: begin
                if (req_own) begin
                    // Saturated count still equals CntMax, so a late requester rotates in at once.
                    if (cnt_inc == CntMax && req_oth) begin
                        state_d    = own_state(oth);
                        beat_cnt_d = '0;
                        rr_ptr_d   = oth;
                    end else begin
                        beat_cnt_d = cnt_inc;
                    end
                end else begin
                    rr_ptr_d   = oth;
                    beat_cnt_d = '0;
                    state_d    = req_oth ? own_state(oth) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_a  = beat ? addr_own  : '0;
        bus.mem_wd = beat ? wdata_own : '0;
        bus.mem_we = beat && we_own && !oor;
        bus.ack0   = beat && !own;
        bus.ack1   = beat && own;
        bus.rdata0 = (bus.ack0 && !oor) ? bus.mem_rd : '0;
        bus.rdata1 = (bus.ack1 && !oor) ? bus.mem_rd : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64x32 memory model; honours DMEM_ARB_RANGE_CHK_EN.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(
        .AW        (32),
        .DW        (32),
        .DEPTH     (64),
        .BURST_MAX (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: combinational read, synchronous write, preloaded with 0x1000_0000 + index.
    logic [31:0] mem [64];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_a[5:0]] <= bus.mem_wd;
        end
    end

    assign bus.mem_rd = mem[bus.mem_a[5:0]];

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
    endtask

    bit [0:9]    b_exp0 = 10'b0111100001;
    bit [0:9]    b_exp1 = 10'b0000011110;
    int unsigned k0, k1, n_ack0, n_ack1;
    logic        a0, a1;

    initial begin
        idle_all();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ack0", bus.ack0, 0);
        check("rst ack1", bus.ack1, 0);
        check("rst mem_we", bus.mem_we, 0);
        check("rst mem_a", bus.mem_a, 0);
        check("rst err", bus.err, 0);
        check("rst rdata0", bus.rdata0, 0);
        next_cycle();
        rst = 1'b1;

        // Single write on port 1, then read back on port 0.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 5; bus.wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        check("A idle ack1", bus.ack1, 0);
        next_cycle();
        @(negedge clk);
        check("A ack1", bus.ack1, 1);
        check("A mem_we", bus.mem_we, 1);
        check("A mem_a", bus.mem_a, 5);
        check("A mem_wd", bus.mem_wd, 32'hDEAD_BEEF);
        check("A ack0 low", bus.ack0, 0);
        next_cycle();
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5;
        @(negedge clk);
        check("A bubble ack0", bus.ack0, 0);
        check("A bubble ack1", bus.ack1, 0);
        check("A bubble mem_we", bus.mem_we, 0);
        next_cycle();
        @(negedge clk);
        check("A rd ack0", bus.ack0, 1);
        check("A rd rdata0", bus.rdata0, 32'hDEAD_BEEF);
        check("A rd rdata1", bus.rdata1, 0);
        next_cycle();
        idle_all();
        next_cycle();

        // Simultaneous streams after reset: port 0 first, forced rotation every 4 beats.
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        k0 = 0; k1 = 0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10; bus.wdata0 = 32'hA0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 20; bus.wdata1 = 32'hB0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("B c%0d ack0", c), bus.ack0, 32'(b_exp0[c]));
            check($sformatf("B c%0d ack1", c), bus.ack1, 32'(b_exp1[c]));
            a0 = bus.ack0;
            a1 = bus.ack1;
            next_cycle();
            if (a0) begin k0++; bus.addr0 = 10 + k0; bus.wdata0 = 32'hA0 + k0; end
            if (a1) begin k1++; bus.addr1 = 20 + k1; bus.wdata1 = 32'hB0 + k1; end
        end
        idle_all();
        next_cycle();
        check("B mem10", mem[10], 32'hA0);
        check("B mem13", mem[13], 32'hA3);
        check("B mem14", mem[14], 32'hA4);
        check("B mem20", mem[20], 32'hB0);
        check("B mem23", mem[23], 32'hB3);
        check("B mem24", mem[24], 32'h1000_0018);

        // Owner release: two reads on port 0, then drop with port 1 waiting.
        bus.req0 = 1'b1; bus.addr0 = 10;
        @(negedge clk);
        check("C idle ack0", bus.ack0, 0);
        next_cycle();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 30; bus.wdata1 = 32'hC0FF_EE00;
        @(negedge clk);
        check("C b1 ack0", bus.ack0, 1);
        check("C b1 rdata0", bus.rdata0, 32'hA0);
        next_cycle();
        bus.addr0 = 11;
        @(negedge clk);
        check("C b2 ack0", bus.ack0, 1);
        check("C b2 rdata0", bus.rdata0, 32'hA1);
        next_cycle();
        bus.req0 = 1'b0;
        @(negedge clk);
        check("C bubble ack0", bus.ack0, 0);
        check("C bubble ack1", bus.ack1, 0);
        check("C bubble mem_we", bus.mem_we, 0);
        next_cycle();
        @(negedge clk);
        check("C ack1", bus.ack1, 1);
        check("C mem_we", bus.mem_we, 1);
        check("C mem_a", bus.mem_a, 30);
        next_cycle();
        idle_all();
        next_cycle();
        check("C mem30", mem[30], 32'hC0FF_EE00);

        // Saturating burst: port 0 alone, then port 1 joins and rotates in after one beat.
        n_ack0 = 0; n_ack1 = 0;
        bus.req0 = 1'b1; bus.addr0 = 11;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            n_ack0 += 32'(bus.ack0);
            n_ack1 += 32'(bus.ack1);
            next_cycle();
        end
        check("D ack0 count", n_ack0, 10);
        check("D ack1 count", n_ack1, 0);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12;
        @(negedge clk);
        check("D sat ack0", bus.ack0, 1);
        check("D sat ack1", bus.ack1, 0);
        next_cycle();
        @(negedge clk);
        check("D rot ack1", bus.ack1, 1);
        check("D rot ack0", bus.ack0, 0);
        check("D rot rdata1", bus.rdata1, 32'hA2);
        next_cycle();
        idle_all();
        next_cycle();

        // Reset asserted in the middle of a port-1 write beat.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 40; bus.wdata1 = 32'h55AA_55AA;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("E pre ack1", bus.ack1, 1);
        check("E pre mem_we", bus.mem_we, 1);
        #2 rst = 1'b0;
        #1;
        check("E rst ack1", bus.ack1, 0);
        check("E rst mem_we", bus.mem_we, 0);
        next_cycle();
        idle_all();
        check("E mem40", mem[40], 32'h1000_0028);
        rst = 1'b1;
        next_cycle();
        bus.req0 = 1'b1; bus.addr0 = 40;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("E rd ack0", bus.ack0, 1);
        check("E rd rdata0", bus.rdata0, 32'h1000_0028);
        next_cycle();
        idle_all();
        next_cycle();

        // Out-of-range write.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 64; bus.wdata0 = 32'h1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("F ack0", bus.ack0, 1);
`ifdef DMEM_ARB_RANGE_CHK_EN
        check("F err", bus.err, 1);
        check("F mem_we", bus.mem_we, 0);
        check("F rdata0", bus.rdata0, 0);
        next_cycle();
        idle_all();
        check("F mem0", mem[0], 32'h1000_0000);
`else
        check("F err", bus.err, 0);
        next_cycle();
        idle_all();
`endif
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single data memory (64 x 32, combinational read, synchronous write) between the CPU load/store path (port 0) and a debug/loader master (port 1).
- Grants ownership by round-robin with a bounded burst length, then drives the memory's WD/A/we from the owner.
- Returns the read word and an ack to the owner.
- Sits between the datapath/debug unit and the memory instance.

Parameters:
- AW, 32, address width; word-indexed, as the memory indexes A directly.
- DW, 32, data width.
- DEPTH, 64, number of memory words; used by the range check.
- BURST_MAX, 4, maximum consecutive beats an owner keeps while the other port is requesting.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req0, req1  in  1 each  access request, ports 0/1.
- we0, we1  in  1 each  write enable, ports 0/1.
- addr0, addr1  in  AW each  word address.
- wdata0, wdata1  in  DW each  write data.
- ack0, ack1  out  1 each  beat completes this cycle.
- rdata0, rdata1  out  DW each  read data, valid while ackN=1.
- err  out  1  range-error pulse (optional feature).
- mem_a  out  AW  to memory A.
- mem_wd  out  DW  to memory WD.
- mem_we  out  1  to memory we.
- mem_rd  in  DW  from memory RD.

Behaviour:
- Reset (rst=0, async), all registers:
  - state=IDLE, rr_ptr=0 (port 0 preferred), beat_cnt=0.
  - Outputs: ack0=ack1=0, err=0, mem_we=0, mem_a=0, mem_wd=0, rdata0=rdata1=0.
- Reset mid-burst drops ownership immediately. No write may issue during reset.
- States: IDLE, OWN0, OWN1. Encoding comes from the package enum.
- IDLE:
  - No access.
  - If any req is high, go to OWNx, where x is the requester; if both request, x=rr_ptr. Set beat_cnt=0.
- OWNx with reqx=1 (a beat):
  - Drive mem_a=addrx, mem_wd=wdatax, mem_we=wex, ackx=1, rdatax=mem_rd in the same cycle.
  - The write commits at this clk edge.
  - beat_cnt increments.
- OWNx with reqx=0: no access, ackx=0.
  - If the other port requests, go to OWNother, reset beat_cnt, and set rr_ptr=other.
  - Otherwise go to IDLE and set rr_ptr=other.
- Forced rotation:
  - Condition: in OWNx, the beat just taken makes beat_cnt==BURST_MAX, and the other req=1.
  - Next state is OWNother, beat_cnt=0, rr_ptr=x^1.
  - If the other port is not requesting, the owner continues and beat_cnt saturates at BURST_MAX.
- Latency:
  - From IDLE, the first ack comes 1 cycle after req rises.
  - Back-to-back beats from the owner: 1 per cycle.
  - Handover costs 1 bubble when the owner drops req. Forced rotation has no bubble: the new owner's beat comes in the next cycle.
- Handshake:
  - A requester holds req/we/addr/wdata stable until its ack.
  - A beat completes exactly in the ack cycle.
  - To stream, keep req high and update fields after each ack.
- Non-owner: ack=0, rdata=0. The non-owner's signals never reach the memory.
- When no beat is active: mem_we=0, mem_a=0, mem_wd=0.
- ack0 and ack1 are never both 1.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHK_EN.
- Defined:
  - A beat with addr >= DEPTH still acks (rdata=0) but forces mem_we=0.
  - err pulses high for that cycle.
- Undefined: err tied 0; addresses pass unchecked.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - port_id_t (1 bit).
  - Default constants DEPTH_DEF=64 and BURST_MAX_DEF=4.
- One natural sub-module, dmem_arb_rr_pick: combinational, takes req0, req1, rr_ptr and outputs the winning port_id and an any_req flag.
- Beat counter and FSM stay in the top.

Test Plan:
- Reset then single request:
  - rst low for 2 cycles, then release; req1=1, we1=1, addr1=5, wdata1=0xDEADBEEF.
  - Expect ack1 the cycle after req.
  - Then req0 read addr0=5 → rdata0=0xDEADBEEF with ack0.
- Simultaneous requests:
  - req0=req1=1 from IDLE after reset → OWN0 first.
  - Port 0 streams; after exactly 4 acks, ownership moves to port 1 with no bubble.
  - Port 1 gets 4 acks, then ownership returns to port 0.
- Owner release:
  - Port 0 does 2 beats then drops req while req1=1 → 1 bubble cycle (no ack, mem_we=0), then ack1.
- Saturating burst:
  - Only port 0 requests for 10 cycles → 10 consecutive acks, no rotation; beat_cnt holds at 4.
- Reset mid-burst:
  - Assert rst during a port-1 write beat before the edge → no write lands; ack1 goes 0 immediately.
  - After release, reading that address returns its prior value.
- Range check (macro defined):
  - Write addr0=64, wdata0=0x1 → ack0=1, err=1, mem_we=0; memory unchanged.
  - Macro undefined → err stays 0.
